// File: rtl/num_char_serializer.sv
//------------------------------------------------------------------------------
// Module   : num_char_serializer (with calc_pkg number type)
// Brief    : Renders one calc_pkg::num_t as fixed-width ASCII, one char/cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpWidth  = 8;

  typedef struct packed {
    logic                          error;
    logic                          sign;
    logic [NumDigits-1:0][3:0]     significand;
    logic signed [ExpWidth-1:0]    exponent;
  } num_t;
endpackage

module num_char_serializer #(
  parameter int NumDigits = calc_pkg::NumDigits,
  parameter int ExpDigits = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  calc_pkg::num_t  num_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [7:0]      char_o,
  output logic            last_o
);

  function automatic int f_pow10(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] f_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  localparam int c_len     = NumDigits + ExpDigits + 5;
  localparam int c_idxw    = $clog2(c_len);
  localparam int c_ew      = calc_pkg::ExpWidth;
  localparam int c_exp_max = f_pow10(ExpDigits) - 1;
  localparam logic [c_idxw-1:0] c_last = c_idxw'(c_len - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [c_idxw-1:0]          r_idx, w_idx_nxt;
  calc_pkg::num_t             r_num;
  logic [ExpDigits-1:0][3:0]  r_exp_bcd, w_exp_bcd;
  logic                       r_exp_neg, r_exp_ovf, w_exp_ovf;
  logic [c_ew-1:0]            w_exp_abs;
  logic                       w_load;
  logic [7:0]                 w_char;

  // Exponent magnitude split into decimal digits as the number is accepted.
  always_comb begin
    int v;
    w_exp_abs = num_i.exponent[c_ew-1] ? $unsigned(-num_i.exponent)
                                       : $unsigned(num_i.exponent);
    w_exp_ovf = int'(w_exp_abs) > c_exp_max;
    w_exp_bcd = '0;
    v = int'(w_exp_abs);
    for (int k = 0; k < ExpDigits; k++) begin
      w_exp_bcd[k] = 4'(v % 10);
      v = v / 10;
    end
  end

  assign w_load = in_valid_i & (r_state == IDLE) & ~clear_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            w_state_nxt = EMIT;
            w_idx_nxt   = '0;
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            if (r_idx == c_last) begin
              w_state_nxt = IDLE;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_num     <= '0;
      r_exp_bcd <= '0;
      r_exp_neg <= 1'b0;
      r_exp_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_num     <= num_i;
        r_exp_bcd <= w_exp_bcd;
        r_exp_neg <= num_i.exponent[c_ew-1];
        r_exp_ovf <= w_exp_ovf;
      end
    end
  end

  // Character selected purely from the captured number and the frame index.
  always_comb begin
    w_char = 8'h20;
    if (r_idx == c_idxw'(0))
      w_char = (r_num.error | r_exp_ovf) ? "E" : " ";
    if (r_idx == c_idxw'(1))
      w_char = r_num.sign ? "-" : " ";
    if (r_idx == c_idxw'(2))
      w_char = f_digit(r_num.significand[NumDigits-1]);
    if (r_idx == c_idxw'(3))
      w_char = ".";
    for (int k = 0; k < NumDigits - 1; k++) begin
      if (r_idx == c_idxw'(4 + k))
        w_char = f_digit(r_num.significand[NumDigits-2-k]);
    end
    if (r_idx == c_idxw'(NumDigits + 3))
      w_char = "e";
    if (r_idx == c_idxw'(NumDigits + 4))
      w_char = r_exp_neg ? "-" : "+";
    for (int k = 0; k < ExpDigits; k++) begin
      if (r_idx == c_idxw'(NumDigits + 5 + k))
        w_char = r_exp_ovf ? 8'h23 : f_digit(r_exp_bcd[ExpDigits-1-k]);
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == EMIT);
  assign char_o      = w_char;
  assign last_o      = (r_state == EMIT) && (r_idx == c_last);

endmodule

`default_nettype wire

// File: tb/tb_num_char_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_num_char_serializer
// Brief    : Table-driven scoreboard bench for num_char_serializer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_num_char_serializer;

  typedef struct packed {
    logic         err;
    logic         sign;
    logic [31:0]  sig;
    logic [7:0]   exp;
    logic [119:0] txt;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  calc_pkg::num_t num;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     ch;
  logic           last;

  vec_t        vecs [7];
  logic [8:0]  q [$];
  logic [119:0] cur_txt;
  int          errors;
  int          checks;
  int          n_hs;
  int          n_last;
  bit          rand_ready;
  bit          bubble;
  bit          stall;
  logic [8:0]  stall_val;

  num_char_serializer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .num_i       (num),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .char_o      (ch),
    .last_o      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst || clear) begin
        q.delete();
        stall  = 0;
        bubble = 0;
      end else begin
        if (bubble)
          chk(!out_valid && in_ready, "bubble", 32'({out_valid, in_ready}), 32'h1);
        bubble = 0;
        if (stall)
          chk(out_valid && ({last, ch} == stall_val), "stall_hold",
              32'({out_valid, last, ch}), 32'({1'b1, stall_val}));
        if (out_valid)
          chk(!in_ready, "busy_ready", 32'(in_ready), 32'h0);
        if (out_valid && out_ready) begin
          chk(q.size() > 0, "sb_nonempty", 32'(q.size()), 32'h1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk({last, ch} == e, "char", 32'({last, ch}), 32'(e));
            if (e[8]) begin
              bubble = 1;
              n_last++;
            end
          end
          n_hs++;
        end
        stall     = out_valid && !out_ready;
        stall_val = {last, ch};
        if (in_valid && in_ready) begin
          for (int i = 0; i < 15; i++)
            q.push_back({(i == 14), cur_txt[8*(14-i) +: 8]});
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input int vi);
    bit acc;
    acc = 0;
    @(posedge clk);
    #1;
    cur_txt  = vecs[vi].txt;
    num      = {vecs[vi].err, vecs[vi].sign, vecs[vi].sig, vecs[vi].exp};
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        break;
      end
    end
    chk(acc, "accept_timeout", 32'(acc), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num      = calc_pkg::num_t'({$urandom, $urandom});
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    chk(done, "drain_timeout", 32'(q.size()), 32'h0);
    @(posedge clk);
  endtask

  task automatic wait_hs(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (n_hs >= target) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "hs_timeout", 32'(n_hs), 32'(target));
  endtask

  initial begin
    int base;
    errors = 0; checks = 0; n_hs = 0; n_last = 0;
    rand_ready = 0; bubble = 0; stall = 0; stall_val = '0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    num = '0; cur_txt = '0;

    vecs[0] = {1'b0, 1'b0, 32'h12345678, 8'h03, "  1.2345678e+03"};
    vecs[1] = {1'b1, 1'b1, 32'h00000000, 8'hF9, "E-0.0000000e-07"};
    vecs[2] = {1'b0, 1'b0, 32'h9C000000, 8'h7B, "E 9.?000000e+##"};
    vecs[3] = {1'b0, 1'b1, 32'h00000005, 8'h00, " -0.0000005e+00"};
    vecs[4] = {1'b0, 1'b0, 32'h99999999, 8'h9D, "  9.9999999e-99"};
    vecs[5] = {1'b0, 1'b0, 32'h10000000, 8'h9C, "E 1.0000000e-##"};
    vecs[6] = {1'b0, 1'b0, 32'hF0000000, 8'h63, "  ?.0000000e+99"};

    fork
      monitor();
      ready_drv();
    join_none

    #2;
    chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'h1);
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
    chk(ch == 8'h20, "rst_char", 32'(ch), 32'h20);
    chk(last == 1'b0, "rst_last", 32'(last), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Every table vector, sink always ready.
    for (int vi = 0; vi < 7; vi++) begin
      send(vi);
      drain();
    end

    // Random back-pressure.
    rand_ready = 1;
    send(0);
    send(2);
    drain();
    rand_ready = 0;

    // Abort at index 5, then an exponent-zero number.
    base = n_hs;
    send(0);
    wait_hs(base + 5);
    #1 clear = 1'b1;
    @(posedge clk);
    #1;
    chk(out_valid == 1'b0 && in_ready == 1'b1, "clear_stop", 32'({out_valid, in_ready}), 32'h1);
    clear = 1'b0;
    send(3);
    drain();

    // Asynchronous reset mid-frame, then two back-to-back frames.
    base = n_hs;
    send(1);
    wait_hs(base + 7);
    #3 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0 && in_ready == 1'b1, "async_rst", 32'({out_valid, in_ready}), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    base = n_last;
    send(0);
    send(4);
    drain();
    chk(n_last - base == 2, "frame_count", 32'(n_last - base), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
